// File: rtl/adc_sampler_pkg.sv
// Shared types and constants for the ADC sampling front end: FSM state
// encoding, sample width, period width and the default timeout budgets.
package adc_sampler_pkg;

   localparam int SAMPLE_W         = 10;
   localparam int PERIOD_W         = 16;
   localparam int DEF_AVG_LOG2     = 3;
   localparam int DEF_BUSY_TIMEOUT = 4;
   localparam int DEF_CONV_TIMEOUT = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_DONE,
      ST_CAPTURE
   } state_e;

   // A programmed period of 0 behaves like 1, so both reload to 0.
   function automatic logic [PERIOD_W-1:0] reload_value(input logic [PERIOD_W-1:0] period);
      return (period == '0) ? '0 : period - PERIOD_W'(1);
   endfunction

endpackage

// File: rtl/sample_averager.sv
// Boxcar averager over 2^AVG_LOG2 captured samples; the closing sample is
// folded in combinationally so avg_valid lines up with that sample's capture.
module sample_averager
   import adc_sampler_pkg::*;
#(
   parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] sample_i,
   input  logic                sample_valid_i,
   input  logic                clear_i,
   output logic [SAMPLE_W-1:0] avg_o,
   output logic                avg_valid_o
);

   localparam int ACC_W = SAMPLE_W + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_W-1:0]    sum;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SAMPLE_W-1:0] avg_q, avg_d;
   logic                avg_valid_q, avg_valid_d;
   logic                last_sample;

   // 2^AVG_LOG2 full-scale samples still fit in ACC_W bits, so no overflow.
   assign sum         = acc_q + ACC_W'(sample_i);
   assign last_sample = (cnt_q == CNT_LAST);

   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      avg_d       = avg_q;
      avg_valid_d = 1'b0;
      if (clear_i) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (sample_valid_i) begin
         if (last_sample) begin
            avg_d       = SAMPLE_W'(sum >> AVG_LOG2);
            avg_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
         end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         avg_q       <= avg_d;
         avg_valid_q <= avg_valid_d;
      end
   end

   assign avg_o       = avg_q;
   assign avg_valid_o = avg_valid_q;

endmodule

// File: rtl/adc_sampler.sv
// Paces ADC conversions from a programmable tick, captures each result and
// publishes raw samples and a boxcar average, with sticky overrun/timeout flags.
module adc_sampler
   import adc_sampler_pkg::*;
#(
   parameter int AVG_LOG2     = DEF_AVG_LOG2,
   parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
   parameter int CONV_TIMEOUT = DEF_CONV_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable_i,
   input  logic [PERIOD_W-1:0] period_i,
   input  logic                clear_err_i,
   output logic                adc_start_o,
   input  logic                adc_done_i,
   input  logic [SAMPLE_W-1:0] adc_dout_i,
   output logic [SAMPLE_W-1:0] sample_o,
   output logic                sample_valid_o,
   output logic [SAMPLE_W-1:0] avg_o,
   output logic                avg_valid_o,
   output logic                overrun_o,
   output logic                timeout_o
);

   localparam int TMR_MAX = (BUSY_TIMEOUT > CONV_TIMEOUT) ? BUSY_TIMEOUT : CONV_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] BUSY_LAST = TMR_W'(BUSY_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] CONV_LAST = TMR_W'(CONV_TIMEOUT - 1);

   logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
   logic                tick;

   state_e              state_q;
   logic [TMR_W-1:0]    tmr_q;
   logic                pend_q;
   logic                adc_start_q;
   logic [SAMPLE_W-1:0] sample_q;
   logic                sample_valid_q;
   logic                overrun_q, overrun_d;
   logic                timeout_q, timeout_d;
   logic                overrun_set, timeout_set;
   logic                capture, avg_clear;

   // Holding at 0 while disabled makes the first enabled cycle tick.
   always_comb begin
      tick       = 1'b0;
      tick_cnt_d = '0;
      if (enable_i) begin
         tick       = (tick_cnt_q == '0);
         tick_cnt_d = tick ? reload_value(period_i) : tick_cnt_q - PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick_cnt_q <= '0;
      else        tick_cnt_q <= tick_cnt_d;
   end

   // Error sets take priority over a clear arriving in the same cycle.
   always_comb begin
      overrun_set = tick && (state_q != ST_IDLE);
      timeout_set = ((state_q == ST_WAIT_BUSY) && adc_done_i  && (tmr_q == BUSY_LAST)) ||
                    ((state_q == ST_WAIT_DONE) && !adc_done_i && (tmr_q == CONV_LAST));
      overrun_d   = overrun_set | (overrun_q & ~clear_err_i);
      timeout_d   = timeout_set | (timeout_q & ~clear_err_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         tmr_q          <= '0;
         pend_q         <= 1'b0;
         adc_start_q    <= 1'b0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         adc_start_q    <= 1'b0;
         sample_valid_q <= 1'b0;
         overrun_q      <= overrun_d;
         timeout_q      <= timeout_d;
         unique case (state_q)
            ST_IDLE: begin
               // A tick seen while the ADC is still finishing a stale frame
               // is held until adc_done returns, not treated as an overrun.
               if (!enable_i) begin
                  pend_q <= 1'b0;
               end else if (tick || pend_q) begin
                  if (adc_done_i) begin
                     state_q     <= ST_START;
                     adc_start_q <= 1'b1;
                     pend_q      <= 1'b0;
                  end else begin
                     pend_q <= 1'b1;
                  end
               end
            end
            ST_START: begin
               state_q <= ST_WAIT_BUSY;
               tmr_q   <= '0;
            end
            ST_WAIT_BUSY: begin
               if (!adc_done_i) begin
                  state_q <= ST_WAIT_DONE;
                  tmr_q   <= '0;
               end else if (tmr_q == BUSY_LAST) begin
                  state_q <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (adc_done_i) begin
                  state_q <= ST_CAPTURE;
               end else if (tmr_q == CONV_LAST) begin
                  state_q <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            ST_CAPTURE: begin
               sample_q       <= adc_dout_i;
               sample_valid_q <= 1'b1;
               state_q        <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // The averager sees the same data and strobe that load sample_q, so its
   // result registers on the same edge as the raw sample.
   assign capture   = (state_q == ST_CAPTURE);
   assign avg_clear = (state_q == ST_IDLE) && !enable_i;

   sample_averager #(
      .AVG_LOG2(AVG_LOG2)
   ) u_avg (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_i      (adc_dout_i),
      .sample_valid_i(capture),
      .clear_i       (avg_clear),
      .avg_o         (avg_o),
      .avg_valid_o   (avg_valid_o)
   );

   assign adc_start_o    = adc_start_q;
   assign sample_o       = sample_q;
   assign sample_valid_o = sample_valid_q;
   assign overrun_o      = overrun_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler: three averaging depths in lockstep behind one
// behavioural ADC, a table of pacing/averaging scenarios and corner sequences.
module tb_adc_sampler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       clear_err = 1'b0;
   logic [15:0] period = 16'd100;
   logic       adc_done = 1'b1;
   logic [9:0] adc_dout = '0;

   // index 0: AVG_LOG2=3, 1: AVG_LOG2=6, 2: AVG_LOG2=0
   logic       st  [3];
   logic [9:0] smp [3];
   logic       sv  [3];
   logic [9:0] avg [3];
   logic       av  [3];
   logic       ovr [3];
   logic       to  [3];

   always #5 clk = ~clk;

   adc_sampler #(.AVG_LOG2(3), .BUSY_TIMEOUT(4), .CONV_TIMEOUT(64)) dut3 (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .period_i(period), .clear_err_i(clear_err),
      .adc_start_o(st[0]), .adc_done_i(adc_done), .adc_dout_i(adc_dout),
      .sample_o(smp[0]), .sample_valid_o(sv[0]), .avg_o(avg[0]), .avg_valid_o(av[0]),
      .overrun_o(ovr[0]), .timeout_o(to[0]));

   adc_sampler #(.AVG_LOG2(6), .BUSY_TIMEOUT(4), .CONV_TIMEOUT(64)) dut6 (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .period_i(period), .clear_err_i(clear_err),
      .adc_start_o(st[1]), .adc_done_i(adc_done), .adc_dout_i(adc_dout),
      .sample_o(smp[1]), .sample_valid_o(sv[1]), .avg_o(avg[1]), .avg_valid_o(av[1]),
      .overrun_o(ovr[1]), .timeout_o(to[1]));

   adc_sampler #(.AVG_LOG2(0), .BUSY_TIMEOUT(4), .CONV_TIMEOUT(64)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable_i(enable), .period_i(period), .clear_err_i(clear_err),
      .adc_start_o(st[2]), .adc_done_i(adc_done), .adc_dout_i(adc_dout),
      .sample_o(smp[2]), .sample_valid_o(sv[2]), .avg_o(avg[2]), .avg_valid_o(av[2]),
      .overrun_o(ovr[2]), .timeout_o(to[2]));

   // Behavioural ADC: 18-state frame, done low for 18 cycles after start.
   // mode 0 normal, 1 ignores start (done stuck high), 2 holds done low 80 cycles.
   int busy_cnt = 0;
   int conv_num = 0;
   int mode = 0;
   int val_base = 0;
   int val_step = 0;
   int num0 = 0;

   always @(negedge clk) begin
      if (busy_cnt > 0) begin
         busy_cnt = busy_cnt - 1;
         if (busy_cnt == 0) begin
            adc_dout = 10'(val_base + (conv_num - num0) * val_step);
            adc_done = 1'b1;
            conv_num = conv_num + 1;
         end
      end else if (st[0] && mode != 1) begin
         adc_done = 1'b0;
         busy_cnt = (mode == 2) ? 80 : 18;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_start = 0, n_sv = 0, n_av3 = 0, n_av6 = 0, n_av0 = 0;
   int bad_coinc = 0, bad_track = 0;
   int last_start_cyc = 0, start_interval = 0;

   always @(negedge clk) begin
      if (st[0]) begin
         start_interval = cyc - last_start_cyc;
         last_start_cyc = cyc;
         n_start = n_start + 1;
      end
      if (sv[0]) begin
         n_sv = n_sv + 1;
         $display("capture %0d: sample=0x%03h avg_valid=%0d avg=0x%03h", n_sv, smp[0], av[0], avg[0]);
      end
      if (av[0]) begin
         n_av3 = n_av3 + 1;
         if (!sv[0]) bad_coinc = bad_coinc + 1;
      end
      if (av[1]) begin
         n_av6 = n_av6 + 1;
         if (!sv[1]) bad_coinc = bad_coinc + 1;
      end
      if (av[2]) n_av0 = n_av0 + 1;
      if ((sv[2] != av[2]) || (av[2] && (avg[2] != smp[2]))) bad_track = bad_track + 1;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_sv(input int target, input int budget, input string name);
      int k = 0;
      while (n_sv < target && k < budget) begin step(); k++; end
      chk(name, n_sv, target);
   endtask

   task automatic wait_start(input int target, input int budget, input string name);
      int k = 0;
      while (n_start < target && k < budget) begin step(); k++; end
      chk(name, n_start, target);
   endtask

   function automatic logic sig_val(input int which);
      case (which)
         0:       return ovr[0];
         1:       return to[0];
         default: return adc_done;
      endcase
   endfunction

   task automatic wait_sig(input int which, input int budget, input string name);
      int k = 0;
      while (sig_val(which) != 1'b1 && k < budget) begin step(); k++; end
      chk(name, int'(sig_val(which)), 1);
   endtask

   task automatic do_reset();
      enable = 1'b0;
      clear_err = 1'b0;
      rst_n = 1'b0;
      for (int k = 0; k < 300 && busy_cnt != 0; k++) step();
      mode = 0;
      num0 = conv_num;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   typedef struct {
      int period; int base; int stp; int n;
      int exp_av3; int exp_avg3; int exp_av6; int exp_avg6; int exp_ovr; int exp_int;
   } row_t;

   row_t rows[5];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b_sv, b_st, b_a3, b_a6, b_a0, b_co, b_tr, t0, d;

      rows[0] = '{100,    0, 1,  8, 1,    3, 0,    0, 0, 100};
      rows[1] = '{ 21, 1023, 0, 64, 8, 1023, 1, 1023, 0,  21};
      rows[2] = '{ 20,    5, 0,  8, 1,    5, 0,    0, 1,  40};
      rows[3] = '{  0,   16, 1,  8, 1,   19, 0,    0, 1,  21};
      rows[4] = '{ 10,  512, 2,  8, 1,  519, 0,    0, 1,  30};

      // reset state
      step(); step();
      chk("rst_adc_start", int'(st[0]), 0);
      chk("rst_sample", int'(smp[0]), 0);
      chk("rst_sample_valid", int'(sv[0]), 0);
      chk("rst_avg", int'(avg[0]), 0);
      chk("rst_avg_valid", int'(av[0]), 0);
      chk("rst_flags", int'({ovr[0], to[0]}), 0);

      for (int r = 0; r < 5; r++) begin
         do_reset();
         period = 16'(rows[r].period);
         val_base = rows[r].base;
         val_step = rows[r].stp;
         b_sv = n_sv; b_st = n_start; b_a3 = n_av3; b_a6 = n_av6; b_a0 = n_av0;
         b_co = bad_coinc; b_tr = bad_track;
         $display("row %0d: period=%0d base=%0d step=%0d samples=%0d",
                  r, rows[r].period, rows[r].base, rows[r].stp, rows[r].n);
         enable = 1'b1;
         wait_sv(b_sv + rows[r].n, rows[r].n * 120 + 200, $sformatf("row%0d_samples", r));
         enable = 1'b0;
         repeat (5) step();
         chk($sformatf("row%0d_starts", r), n_start - b_st, rows[r].n);
         chk($sformatf("row%0d_interval", r), start_interval, rows[r].exp_int);
         chk($sformatf("row%0d_last_sample", r), int'(smp[0]),
             (rows[r].base + (rows[r].n - 1) * rows[r].stp) & 10'h3FF);
         chk($sformatf("row%0d_avg3_count", r), n_av3 - b_a3, rows[r].exp_av3);
         chk($sformatf("row%0d_avg3", r), int'(avg[0]), rows[r].exp_avg3);
         chk($sformatf("row%0d_avg6_count", r), n_av6 - b_a6, rows[r].exp_av6);
         chk($sformatf("row%0d_avg6", r), int'(avg[1]), rows[r].exp_avg6);
         chk($sformatf("row%0d_avg0_count", r), n_av0 - b_a0, rows[r].n);
         chk($sformatf("row%0d_avg0_tracks", r), bad_track - b_tr, 0);
         chk($sformatf("row%0d_avg_coincident", r), bad_coinc - b_co, 0);
         chk($sformatf("row%0d_overrun", r), int'(ovr[0]), rows[r].exp_ovr);
         chk($sformatf("row%0d_timeout", r), int'(to[0]), 0);
      end

      // overrun: first dropped tick, clear, re-set on next drop
      do_reset();
      period = 16'd10; val_base = 7; val_step = 0;
      b_sv = n_sv;
      enable = 1'b1;
      wait_sig(0, 60, "ovr_sets");
      chk("ovr_before_capture", n_sv - b_sv, 0);
      clear_err = 1'b1; step(); clear_err = 1'b0;
      chk("ovr_cleared", int'(ovr[0]), 0);
      wait_sig(0, 15, "ovr_resets");
      $display("seq overrun clear/re-set done");

      // clear_err coinciding with a dropped tick: the set wins
      do_reset();
      period = 16'd0;
      b_st = n_start;
      enable = 1'b1;
      wait_start(b_st + 1, 10, "setwin_start");
      repeat (4) step();
      clear_err = 1'b1; step(); clear_err = 1'b0;
      chk("ovr_set_wins", int'(ovr[0]), 1);
      enable = 1'b0;
      repeat (30) step();
      $display("seq set-wins done");

      // busy timeout: adc_done never falls
      do_reset();
      mode = 1; period = 16'd100;
      b_sv = n_sv; b_st = n_start;
      enable = 1'b1;
      wait_start(b_st + 1, 10, "busy_to_start");
      t0 = last_start_cyc;
      wait_sig(1, 20, "busy_to_sets");
      d = cyc - t0;
      enable = 1'b0;
      chk("busy_to_delay_in_4_6", int'(d >= 4 && d <= 6), 1);
      chk("busy_to_no_sample", n_sv - b_sv, 0);
      clear_err = 1'b1; step(); clear_err = 1'b0;
      chk("busy_to_cleared", int'(to[0]), 0);
      $display("seq busy timeout delay=%0d", d);

      // conversion timeout: adc_done held low for 80 cycles
      do_reset();
      mode = 2; period = 16'd100;
      b_sv = n_sv; b_st = n_start;
      enable = 1'b1;
      wait_start(b_st + 1, 10, "conv_to_start");
      t0 = last_start_cyc;
      wait_sig(1, 100, "conv_to_sets");
      d = cyc - t0;
      enable = 1'b0;
      chk("conv_to_delay_in_64_68", int'(d >= 64 && d <= 68), 1);
      chk("conv_to_no_sample", n_sv - b_sv, 0);
      $display("seq conversion timeout delay=%0d", d);

      // enable dropped mid-conversion after 3 samples
      do_reset();
      period = 16'd30; val_base = 0; val_step = 1;
      b_sv = n_sv; b_st = n_start; b_a3 = n_av3;
      enable = 1'b1;
      wait_start(b_st + 4, 150, "en_fourth_start");
      repeat (5) step();
      enable = 1'b0;
      repeat (40) step();
      chk("en_fourth_captured", n_sv - b_sv, 4);
      chk("en_fourth_value", int'(smp[0]), 3);
      chk("en_no_avg", n_av3 - b_a3, 0);
      enable = 1'b1;
      wait_sv(b_sv + 11, 300, "en_seven_fresh");
      chk("en_no_avg_after_7", n_av3 - b_a3, 0);
      wait_sv(b_sv + 12, 60, "en_eight_fresh");
      chk("en_avg_after_8", n_av3 - b_a3, 1);
      chk("en_avg_value", int'(avg[0]), 7);
      enable = 1'b0;
      repeat (5) step();
      $display("seq enable drop done");

      // reset mid-conversion
      do_reset();
      period = 16'd200; val_base = 10'h155; val_step = 0;
      b_sv = n_sv; b_st = n_start;
      enable = 1'b1;
      wait_sv(b_sv + 1, 40, "rst_first_capture");
      chk("rst_first_value", int'(avg[2]), 10'h155);
      wait_start(b_st + 2, 250, "rst_second_start");
      chk("rst_start_high", int'(st[0]), 1);
      val_base = 10'h100; val_step = 1; num0 = conv_num;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_start", int'(st[0]), 0);
      chk("rst_async_sample", int'(smp[0]), 0);
      chk("rst_async_avg", int'(avg[2]), 0);
      step(); step();
      rst_n = 1'b1;
      b_st = n_start; b_sv = n_sv;
      wait_sig(2, 40, "rst_adc_done_back");
      chk("rst_no_start_while_busy", n_start - b_st, 0);
      wait_sv(b_sv + 1, 60, "rst_next_capture");
      chk("rst_next_value", int'(smp[0]), 10'h101);
      chk("rst_no_overrun", int'(ovr[0]), 0);
      enable = 1'b0;
      repeat (5) step();
      $display("seq reset mid-conversion done");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
